// File: rtl/maxnet_engine.sv
// Winner-take-all iteration engine for a 4-node MaxNet with symmetric Q1.3 weights.
// Optional define MAXNET_TIE_BREAK_EN: on timeout report the lowest-index maximum as a valid winner.
module maxnet_engine #(
   parameter int DATA_W   = 8,
   parameter int FRAC_W   = 3,
   parameter int MAX_ITER = 31,
   parameter int ITER_W   = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DATA_W-1:0] x_in,
   input  logic [49:0]         weights_in,
   output logic                busy,
   output logic                done,
   output logic                valid,
   output logic                timeout,
   output logic [1:0]          winner,
   output logic [DATA_W-1:0]   winner_val,
   output logic [ITER_W-1:0]   iter_count
);

   localparam int PROD_W = DATA_W + 6;
   localparam int NET_W  = DATA_W + 8;
   localparam logic signed [NET_W-1:0] ACT_MAX = $signed({{(NET_W-DATA_W){1'b0}}, {DATA_W{1'b1}}});

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                    state_r, state_next_s;
   logic [DATA_W-1:0]         act_r [4];
   logic [DATA_W-1:0]         act_next_s [4];
   logic [ITER_W-1:0]         iter_r;
   logic [4:0]                wmat_s [4][4];
   logic signed [PROD_W-1:0]  a_ext_s, w_ext_s, prod_s;
   logic signed [NET_W-1:0]   net_s [4];
   logic signed [NET_W-1:0]   shr_s [4];
   logic [2:0]                nz_cnt_s;
   logic [1:0]                single_idx_s;
   logic                      finish_s;
   logic                      busy_r, done_r, valid_r, timeout_r;
   logic [1:0]                winner_r;
   logic [DATA_W-1:0]         winner_val_r;
   logic [ITER_W-1:0]         iter_count_r;
`ifdef MAXNET_TIE_BREAK_EN
   logic [1:0]                max_idx_s;
`endif

   // Only the upper triangle is stored; w(j,i) and w(i,j) share one slot.
   function automatic int widx(input int j, input int i);
      int lo;
      int hi;
      lo = (j < i) ? j : i;
      hi = (j < i) ? i : j;
      case (lo)
         0:       return hi;
         1:       return hi + 3;
         2:       return hi + 5;
         default: return 9;
      endcase
   endfunction

   // Expand the packed weight bus into a full symmetric matrix.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            wmat_s[j][i] = weights_in[5*widx(j, i) +: 5];
         end
      end
   end

   // One MaxNet step: weighted sum, floor shift, clamp to [0, 2^DATA_W-1].
   always_comb begin
      a_ext_s = '0;
      w_ext_s = '0;
      prod_s  = '0;
      for (int j = 0; j < 4; j++) begin
         net_s[j] = '0;
         for (int i = 0; i < 4; i++) begin
            a_ext_s  = {{(PROD_W-DATA_W){1'b0}}, act_r[i]};
            w_ext_s  = {{(PROD_W-5){wmat_s[j][i][4]}}, wmat_s[j][i]};
            prod_s   = a_ext_s * w_ext_s;
            net_s[j] = net_s[j] + {{(NET_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
         end
         shr_s[j] = net_s[j] >>> FRAC_W;
         if (shr_s[j][NET_W-1]) begin
            act_next_s[j] = '0;
         end else if (shr_s[j] > ACT_MAX) begin
            act_next_s[j] = '1;
         end else begin
            act_next_s[j] = shr_s[j][DATA_W-1:0];
         end
      end
   end

   // Termination status of the current activations.
   always_comb begin
      nz_cnt_s     = 3'd0;
      single_idx_s = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (act_r[k] != '0) begin
            nz_cnt_s     = nz_cnt_s + 3'd1;
            single_idx_s = 2'(k);
         end else begin
            nz_cnt_s     = nz_cnt_s;
         end
      end
`ifdef MAXNET_TIE_BREAK_EN
      max_idx_s = 2'd0;
      for (int k = 1; k < 4; k++) begin
         if (act_r[k] > act_r[max_idx_s]) begin
            max_idx_s = 2'(k);
         end else begin
            max_idx_s = max_idx_s;
         end
      end
`endif
      finish_s = (nz_cnt_s <= 3'd1) || (iter_r == ITER_W'(MAX_ITER));
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = RUN;
            else       state_next_s = IDLE;
         end
         RUN: begin
            if (finish_s) state_next_s = DONE;
            else          state_next_s = RUN;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_next_s;
   end

   // Activations, iteration counter and held result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) act_r[k] <= '0;
         iter_r       <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         valid_r      <= 1'b0;
         timeout_r    <= 1'b0;
         winner_r     <= 2'd0;
         winner_val_r <= '0;
         iter_count_r <= '0;
      end else begin
         busy_r <= (state_next_s == RUN);
         done_r <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  for (int k = 0; k < 4; k++) act_r[k] <= x_in[k*DATA_W +: DATA_W];
                  iter_r    <= '0;
                  valid_r   <= 1'b0;
                  timeout_r <= 1'b0;
               end
            end
            RUN: begin
               if (nz_cnt_s == 3'd1) begin
                  valid_r      <= 1'b1;
                  winner_r     <= single_idx_s;
                  winner_val_r <= act_r[single_idx_s];
                  iter_count_r <= iter_r;
               end else if (nz_cnt_s == 3'd0) begin
                  valid_r      <= 1'b0;
                  winner_r     <= 2'd0;
                  winner_val_r <= '0;
                  iter_count_r <= iter_r;
               end else if (iter_r == ITER_W'(MAX_ITER)) begin
                  timeout_r    <= 1'b1;
                  iter_count_r <= iter_r;
`ifdef MAXNET_TIE_BREAK_EN
                  valid_r      <= 1'b1;
                  winner_r     <= max_idx_s;
                  winner_val_r <= act_r[max_idx_s];
`else
                  valid_r      <= 1'b0;
                  winner_r     <= 2'd0;
                  winner_val_r <= '0;
`endif
               end else begin
                  for (int k = 0; k < 4; k++) act_r[k] <= act_next_s[k];
                  iter_r <= iter_r + ITER_W'(1);
               end
            end
            default: iter_r <= iter_r;
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign valid      = valid_r;
   assign timeout    = timeout_r;
   assign winner     = winner_r;
   assign winner_val = winner_val_r;
   assign iter_count = iter_count_r;

endmodule
